// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and widths for the MulAdder dot-product sequencer.
// No logic: state encoding, datapath widths, default pipeline latency.
package mac_job_sequencer_pkg;

    localparam int MUL_A_W     = 16;
    localparam int MUL_C_W     = 48;
    localparam int MUL_P_W     = 36;
    localparam int MUL_LAT_DEF = 3;
    localparam int LEN_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // The C port is wider than P; the running sum is sign-extended onto it.
    function automatic logic [MUL_C_W-1:0] sext_c(input logic [MUL_P_W-1:0] v);
        return {{(MUL_C_W-MUL_P_W){v[MUL_P_W-1]}}, v};
    endfunction

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Job control, operand stream, MulAdder port and result stream of the sequencer.
// slave = the sequencer, master = controller / operand buffer / MulAdder side.
interface mac_job_sequencer_if
    import mac_job_sequencer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
);

    logic               start;
    logic               clear;
    logic [LEN_W-1:0]   len;
    logic [MUL_P_W-1:0] bias;
    logic               sub_mode;

    logic               in_valid;
    logic               in_ready;
    logic [MUL_A_W-1:0] in_w;
    logic [MUL_A_W-1:0] in_x;

    logic               mul_ce;
    logic               mul_sclr;
    logic [MUL_A_W-1:0] mul_a;
    logic [MUL_A_W-1:0] mul_b;
    logic [MUL_C_W-1:0] mul_c;
    logic               mul_sub;
    logic [MUL_P_W-1:0] mul_p;

    logic               out_valid;
    logic               out_ready;
    logic [MUL_P_W-1:0] out_data;
    logic               busy;

    modport slave (
        input  start, clear, len, bias, sub_mode,
        input  in_valid, in_w, in_x,
        output in_ready,
        output mul_ce, mul_sclr, mul_a, mul_b, mul_c, mul_sub,
        input  mul_p,
        output out_valid, out_data, busy,
        input  out_ready
    );

    modport master (
        output start, clear, len, bias, sub_mode,
        output in_valid, in_w, in_x,
        input  in_ready,
        input  mul_ce, mul_sclr, mul_a, mul_b, mul_c, mul_sub,
        output mul_p,
        input  out_valid, out_data, busy,
        output out_ready
    );

endinterface

// File: rtl/mac_wait_timer.sv
// Loadable down-counter: done is high in the LAT-th enabled cycle after load.
// No backpressure; clr and load take effect on the next edge.
module mac_wait_timer #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LAT - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = en && (cnt == '0);

endmodule

// File: rtl/mac_job_sequencer.sv
// Drives one MulAdder through bias +/- sum(w*x); one element per MUL_LAT+1 cycles.
// Operands stall via in_ready outside ISSUE; the result is held in DONE until out_ready.
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic system_clk,
    input  logic rst_n,
    mac_job_sequencer_if.slave bus
);

    seq_state_t         state;
    logic [MUL_P_W-1:0] acc;
    logic [LEN_W-1:0]   remaining;
    logic               sub;

    logic in_hs;
    logic out_hs;
    logic timer_load;
    logic timer_en;
    logic wait_done;

    assign in_hs      = bus.in_valid && bus.in_ready;
    assign out_hs     = bus.out_valid && bus.out_ready;
    assign timer_load = (state == ST_ISSUE) && in_hs && !bus.clear;
    assign timer_en   = (state == ST_WAIT);

    mac_wait_timer #(
        .LAT (MUL_LAT)
    ) u_wait_timer (
        .clk   (system_clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .load  (timer_load),
        .en    (timer_en),
        .done  (wait_done)
    );

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            acc          <= '0;
            remaining    <= '0;
            sub          <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.mul_ce   <= 1'b0;
            bus.mul_sclr <= 1'b0;
            bus.mul_a    <= '0;
            bus.mul_b    <= '0;
            bus.mul_c    <= '0;
            bus.mul_sub  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.mul_sclr <= 1'b0;
            // clear overrides everything, including handshakes in the same cycle
            if (bus.clear) begin
                state         <= ST_IDLE;
                bus.in_ready  <= 1'b0;
                bus.out_valid <= 1'b0;
                bus.mul_ce    <= 1'b0;
                bus.mul_sclr  <= 1'b1;
                bus.busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            acc          <= bus.bias;
                            remaining    <= bus.len;
                            sub          <= bus.sub_mode;
                            bus.mul_sclr <= 1'b1;
                            bus.busy     <= 1'b1;
                            if (bus.len != '0) begin
                                state        <= ST_ISSUE;
                                bus.in_ready <= 1'b1;
                            end else begin
                                state         <= ST_DONE;
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= bus.bias;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (in_hs) begin
                            bus.mul_a    <= bus.in_w;
                            bus.mul_b    <= bus.in_x;
                            bus.mul_c    <= sext_c(acc);
                            bus.mul_sub  <= sub;
                            bus.mul_ce   <= 1'b1;
                            bus.in_ready <= 1'b0;
                            remaining    <= remaining - LEN_W'(1);
                            state        <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // P is sampled on the edge that closes the last enabled cycle
                        if (wait_done) begin
                            acc        <= bus.mul_p;
                            bus.mul_ce <= 1'b0;
                            if (remaining != '0) begin
                                state        <= ST_ISSUE;
                                bus.in_ready <= 1'b1;
                            end else begin
                                state         <= ST_DONE;
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= bus.mul_p;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (out_hs) begin
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Scoreboard bench: expected job results are queued at stimulus time and
// popped when the sequencer hands a result over; a behavioural MulAdder closes the loop.
module tb_mac_job_sequencer;
    import mac_job_sequencer_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int LEN_W   = 16;

    logic system_clk = 1'b0;
    logic rst_n      = 1'b0;

    mac_job_sequencer_if #(.LEN_W(LEN_W)) bus();

    mac_job_sequencer #(
        .MUL_LAT (MUL_LAT),
        .LEN_W   (LEN_W)
    ) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 system_clk = ~system_clk;

    // Behavioural MulAdder: P is ready to be sampled on the MUL_LAT-th enabled edge
    logic signed [31:0] prod;
    logic [35:0]        p_pipe [MUL_LAT-1];
    assign prod      = $signed(bus.mul_a) * $signed(bus.mul_b);
    assign bus.mul_p = p_pipe[MUL_LAT-2];

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT-1; i++) p_pipe[i] <= '0;
        end else if (bus.mul_sclr) begin
            for (int i = 0; i < MUL_LAT-1; i++) p_pipe[i] <= '0;
        end else if (bus.mul_ce) begin
            p_pipe[0] <= bus.mul_sub ? bus.mul_c[35:0] - {{4{prod[31]}}, prod}
                                     : bus.mul_c[35:0] + {{4{prod[31]}}, prod};
            for (int i = 1; i < MUL_LAT-1; i++) p_pipe[i] <= p_pipe[i-1];
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          t0    = 0;
    int          ce_bad = 0;
    int          ce_cycles = 0;
    logic        prev_ce = 1'b0;
    logic [79:0] prev_abc = '0;
    logic [35:0] sbq [$];
    int          pw [$];
    int          px [$];

    always @(posedge system_clk) cyc++;

    // CE may only be high in WAIT, and A/B/C must not move while it is
    always @(negedge system_clk) begin
        if (rst_n && bus.mul_ce) begin
            ce_cycles++;
            if (bus.in_ready || !bus.busy || bus.out_valid) ce_bad++;
            if (prev_ce && ({bus.mul_a, bus.mul_b, bus.mul_c} != prev_abc)) ce_bad++;
        end
        prev_ce  = bus.mul_ce;
        prev_abc = {bus.mul_a, bus.mul_b, bus.mul_c};
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic [35:0] b, input logic s);
        logic [35:0] a;
        int          p;
        a = b;
        for (int i = 0; i < pw.size(); i++) begin
            p = pw[i] * px[i];
            a = s ? a - 36'(p) : a + 36'(p);
        end
        return a;
    endfunction

    task automatic start_job(input logic [35:0] b, input int n, input logic s);
        bus.bias     = b;
        bus.len      = LEN_W'(n);
        bus.sub_mode = s;
        bus.start    = 1'b1;
        t0           = cyc;
        @(negedge system_clk);
        bus.start    = 1'b0;
    endtask

    task automatic send_one(input int w, input int x);
        int k;
        bus.in_w     = 16'(w);
        bus.in_x     = 16'(x);
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 60) begin
            @(negedge system_clk);
            k++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 48'd0, 48'd1);
        @(negedge system_clk);
    endtask

    task automatic feed(input int gap, input logic rnd_gap);
        int g;
        for (int i = 0; i < pw.size(); i++) begin
            send_one(pw[i], px[i]);
            g = rnd_gap ? int'($urandom_range(0, 3)) : gap;
            if (g > 0) begin
                bus.in_valid = 1'b0;
                repeat (g) @(negedge system_clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold, input int exp_lat);
        int          k;
        logic [35:0] exp;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge system_clk);
            k++;
        end
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 48'd0, 48'd1);
            return;
        end
        if (exp_lat >= 0) chk({tag, "_latency"}, 48'(cyc - t0), 48'(exp_lat));
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 48'd0, 48'd1);
            return;
        end
        exp = sbq.pop_front();
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold"}, {11'd0, bus.out_valid, bus.out_data}, {11'd0, 1'b1, exp});
            bus.start = h[0];
            bus.len   = LEN_W'(1);
            @(negedge system_clk);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_data"}, 48'(bus.out_data), 48'(exp));
        @(negedge system_clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, {46'd0, bus.busy, bus.out_valid}, 48'd0);
        if (hold > 0) begin
            @(negedge system_clk);
            chk({tag, "_start_ignored"}, 48'(bus.busy), 48'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int          ce0;
        logic        rs;
        logic [35:0] rb;
        bus.start = 1'b0; bus.clear = 1'b0; bus.len = '0; bus.bias = '0; bus.sub_mode = 1'b0;
        bus.in_valid = 1'b0; bus.in_w = '0; bus.in_x = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge system_clk);
        chk("rst_ctrl", {42'd0, bus.in_ready, bus.mul_ce, bus.mul_sclr, bus.mul_sub, bus.out_valid, bus.busy}, 48'd0);
        chk("rst_mul_c", bus.mul_c, 48'd0);
        chk("rst_out_data", 48'(bus.out_data), 48'd0);
        rst_n = 1'b1;
        @(negedge system_clk);

        // Job 1: back-to-back operands, exact latency
        pw = '{-10, 10, -8}; px = '{-5, -5, 2};
        sbq.push_back(-36'sd16);
        ce0 = ce_cycles;
        start_job(36'd0, 3, 1'b0);
        feed(0, 1'b0);
        collect("j1", 0, 3 * (MUL_LAT + 1) + 1);
        chk("j1_ce_cycles", 48'(ce_cycles - ce0), 48'(3 * MUL_LAT));

        // Job 2: subtract mode with bubbles on the operand stream
        pw = '{3, 2}; px = '{4, 5};
        sbq.push_back(36'd78);
        ce0 = ce_cycles;
        start_job(36'd100, 2, 1'b1);
        feed(4, 1'b0);
        collect("j2", 0, -1);
        chk("j2_ce_cycles", 48'(ce_cycles - ce0), 48'(2 * MUL_LAT));
        chk("j2_ce_window", 48'(ce_bad), 48'd0);

        // Job 3: empty job returns the bias
        pw = {}; px = {};
        sbq.push_back(-36'sd20);
        ce0 = ce_cycles;
        start_job(-36'sd20, 0, 1'b0);
        collect("j3", 0, 1);
        chk("j3_ce_cycles", 48'(ce_cycles - ce0), 48'd0);

        // Job 4: output backpressure with stray start pulses
        pw = '{7}; px = '{-3};
        sbq.push_back(36'd979);
        start_job(36'd1000, 1, 1'b0);
        feed(0, 1'b0);
        collect("j4", 6, -1);

        // Job 5: clear in the second WAIT cycle of element 2
        start_job(36'd0, 3, 1'b0);
        send_one(1, 1);
        send_one(2, 2);
        bus.in_valid = 1'b0;
        @(negedge system_clk);
        bus.clear = 1'b1;
        @(negedge system_clk);
        bus.clear = 1'b0;
        chk("clr_state", {44'd0, bus.busy, bus.mul_sclr, bus.mul_ce, bus.in_ready}, 48'b0100);
        @(negedge system_clk);
        chk("clr_sclr_once", 48'(bus.mul_sclr), 48'd0);
        pw = '{2}; px = '{3};
        sbq.push_back(36'd11);
        start_job(36'd5, 1, 1'b0);
        feed(0, 1'b0);
        collect("j5", 0, 2 * (MUL_LAT + 1) - 3);

        // Job 6: accumulator wraps modulo 2^36
        pw = '{1}; px = '{1};
        sbq.push_back(36'h8_0000_0000);
        start_job(36'h7_FFFF_FFFF, 1, 1'b0);
        feed(0, 1'b0);
        collect("j6", 0, -1);

        // Random job against the arithmetic model
        pw = {}; px = {};
        for (int i = 0; i < 6; i++) begin
            pw.push_back(int'($urandom_range(0, 65535)) - 32768);
            px.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
        rs = 1'($urandom_range(0, 1));
        rb = {4'($urandom_range(0, 15)), 32'($urandom)};
        sbq.push_back(model(rb, rs));
        start_job(rb, 6, rs);
        feed(0, 1'b1);
        collect("jrnd", 0, -1);
        chk("ce_window", 48'(ce_bad), 48'd0);

        // Asynchronous reset in the middle of WAIT
        start_job(36'd0, 1, 1'b0);
        send_one(5, 6);
        chk("pre_rst_ce", 48'(bus.mul_ce), 48'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {42'd0, bus.in_ready, bus.mul_ce, bus.mul_sclr, bus.mul_sub, bus.out_valid, bus.busy}, 48'd0);
        chk("arst_ab", {16'd0, bus.mul_a, bus.mul_b}, 48'd0);
        chk("arst_c", bus.mul_c, 48'd0);
        bus.in_valid = 1'b0;
        @(negedge system_clk);
        rst_n = 1'b1;
        @(negedge system_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
